pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl_pkg.sv | 13 +
 rtl/pong_btn_edge.sv | 13 +
 rtl/pong_game_ctrl.sv | 115 +++++++++++
 tb/tb_pong_game_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_game_ctrl_pkg.sv
// pong_game_ctrl_pkg: shared state encoding, defaults and direction codes for the pong game controller.
package pong_game_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_PLAY, S_POINT, S_OVER} state_t;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_POINT_FRAMES = 30;
  localparam int DEF_WIN_SCORE = 9;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic [3:0] SCORE_MAX = 4'd15;
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == SCORE_MAX) ? s : s + 4'd1;
  endfunction
endpackage

// File: rtl/pong_btn_edge.sv
// pong_btn_edge: two-flop synchroniser plus rising-edge detector for asynchronous buttons and switches.
module pong_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s3, s2, s1} <= 3'b000;
    else {s3, s2, s1} <= {s2, s1, btn};
  assign rise = s2 & ~s3;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-flow FSM sequencing arm/serve, rally, point pause and game over, and keeping score.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int WIN_SCORE = DEF_WIN_SCORE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       frame_tick,
  input  logic       exit_left,
  input  logic       exit_right,
  output logic       serve,
  output logic       serve_dir,
  output logic       ball_en,
  output logic       paddle_en,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       game_over,
  output logic       winner
);
  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CW = $clog2(MAX_FRAMES + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic start_evt;
  logic [3:0] left_next, right_next;
  pong_btn_edge u_start (
    .clk (clk),
    .rst (rst),
    .btn (start_btn),
    .rise(start_evt)
  );
  assign left_next = sat_inc(left_score);
  assign right_next = sat_inc(right_score);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      serve <= 1'b0;
      serve_dir <= DIR_RIGHT;
      ball_en <= 1'b0;
      paddle_en <= 1'b0;
      left_score <= 4'd0;
      right_score <= 4'd0;
      game_over <= 1'b0;
      winner <= 1'b0;
    end else begin
      serve <= 1'b0;
      case (state)
        S_IDLE, S_OVER:
          if (start_evt) begin
            state <= S_ARM;
            cnt <= CW'(SERVE_FRAMES);
            serve_dir <= DIR_RIGHT;
            left_score <= 4'd0;
            right_score <= 4'd0;
            paddle_en <= 1'b1;
            game_over <= 1'b0;
            winner <= 1'b0;
          end
        S_ARM:
          if (frame_tick) begin
            if (cnt <= CW'(1)) begin
              state <= S_PLAY;
              cnt <= '0;
              serve <= 1'b1;
              ball_en <= 1'b1;
            end else cnt <= cnt - 1'b1;
          end
        S_PLAY:
          if (exit_left && exit_right) begin
            state <= S_POINT;
            cnt <= CW'(POINT_FRAMES);
            ball_en <= 1'b0;
          end else if (exit_left) begin
            right_score <= right_next;
            serve_dir <= DIR_LEFT;
            ball_en <= 1'b0;
            if (right_next == 4'(WIN_SCORE)) begin
              state <= S_OVER;
              paddle_en <= 1'b0;
              game_over <= 1'b1;
              winner <= DIR_RIGHT;
            end else begin
              state <= S_POINT;
              cnt <= CW'(POINT_FRAMES);
            end
          end else if (exit_right) begin
            left_score <= left_next;
            serve_dir <= DIR_RIGHT;
            ball_en <= 1'b0;
            if (left_next == 4'(WIN_SCORE)) begin
              state <= S_OVER;
              paddle_en <= 1'b0;
              game_over <= 1'b1;
              winner <= DIR_LEFT;
            end else begin
              state <= S_POINT;
              cnt <= CW'(POINT_FRAMES);
            end
          end
        S_POINT:
          if (frame_tick) begin
            if (cnt <= CW'(1)) begin
              state <= S_ARM;
              cnt <= CW'(SERVE_FRAMES);
            end else cnt <= cnt - 1'b1;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scenarios and random play checked against a frame-counting game model.
module tb_pong_game_ctrl;
  localparam int SF = 60;
  localparam int PF = 30;
  localparam int WS = 9;
  localparam int P_IDLE = 0, P_ARM = 1, P_PLAY = 2, P_POINT = 3, P_OVER = 4;
  logic clk = 1'b0, rst = 1'b0, start_btn = 1'b0, frame_tick = 1'b0, exit_left = 1'b0, exit_right = 1'b0;
  logic serve, serve_dir, ball_en, paddle_en, game_over, winner;
  logic [3:0] left_score, right_score;
  int vectors = 0, errors = 0, evt_count = 0;
  int m_ph, m_frames, m_left, m_right;
  bit m_dir, m_win, m_serve, ms1, ms2, ms3;
  always #5 clk = ~clk;
  pong_game_ctrl #(.SERVE_FRAMES(SF), .POINT_FRAMES(PF), .WIN_SCORE(WS)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .frame_tick(frame_tick),
    .exit_left(exit_left), .exit_right(exit_right), .serve(serve), .serve_dir(serve_dir),
    .ball_en(ball_en), .paddle_en(paddle_en), .left_score(left_score), .right_score(right_score),
    .game_over(game_over), .winner(winner)
  );
  task automatic model_reset();
    m_ph = P_IDLE; m_frames = 0; m_left = 0; m_right = 0;
    m_dir = 1'b1; m_win = 1'b0; m_serve = 1'b0; ms1 = 1'b0; ms2 = 1'b0; ms3 = 1'b0;
  endtask
  task automatic model_score(input bit right_scored);
    int s;
    if (right_scored) begin m_right = (m_right < 15) ? m_right + 1 : 15; m_dir = 1'b0; s = m_right; end
    else begin m_left = (m_left < 15) ? m_left + 1 : 15; m_dir = 1'b1; s = m_left; end
    if (s == WS) begin m_ph = P_OVER; m_win = right_scored; end
    else begin m_ph = P_POINT; m_frames = PF; end
  endtask
  task automatic step(input bit b, input bit tk, input bit el, input bit er);
    bit evt;
    start_btn = b; frame_tick = tk; exit_left = el; exit_right = er;
    @(posedge clk);
    evt = ms2 && !ms3; ms3 = ms2; ms2 = ms1; ms1 = b;
    m_serve = 1'b0;
    if (!rst) model_reset();
    else case (m_ph)
      P_IDLE, P_OVER: if (evt) begin
        m_left = 0; m_right = 0; m_frames = SF; m_dir = 1'b1; m_win = 1'b0; m_ph = P_ARM;
      end
      P_ARM: if (tk) begin
        m_frames--;
        if (m_frames == 0) begin m_ph = P_PLAY; m_serve = 1'b1; end
      end
      P_PLAY: if (el && er) begin m_ph = P_POINT; m_frames = PF; end
              else if (el) model_score(1'b1);
              else if (er) model_score(1'b0);
      P_POINT: if (tk) begin
        m_frames--;
        if (m_frames == 0) begin m_frames = SF; m_ph = P_ARM; end
      end
      default: ;
    endcase
    #1;
    if (dut.start_evt) evt_count++;
  endtask
  task automatic press_start();
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_reset();
    model_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({serve, serve_dir, ball_en, paddle_en, game_over, winner, left_score, right_score} !== 14'b01_0000_0000_0000) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", {serve, serve_dir, ball_en, paddle_en, game_over, winner, left_score, right_score}, 14'b01_0000_0000_0000);
    end
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (paddle_en !== 1'b0 || right_score !== 4'd0) begin
      errors++;
      $display("FAIL idle_ignores_exit: got paddle_en=%b right=%0d expected 0/0", paddle_en, right_score);
    end
  endtask
  task automatic test_serve();
    int serves = 0;
    press_start();
    vectors++;
    if (paddle_en !== 1'b1 || ball_en !== 1'b0) begin
      errors++;
      $display("FAIL arm_entry: got paddle_en=%b ball_en=%b expected 1/0", paddle_en, ball_en);
    end
    for (int i = 1; i <= SF; i++) begin
      repeat ($urandom_range(0, 2)) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        if (serve) serves++;
      end
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (serve) serves++;
      vectors++;
      if (serve !== m_serve) begin
        errors++;
        $display("FAIL serve_timing tick %0d: got serve=%b expected %b", i, serve, m_serve);
      end
    end
    vectors++;
    if ({serve, serve_dir, ball_en} !== 3'b111) begin
      errors++;
      $display("FAIL serve_outputs: got %b expected 111", {serve, serve_dir, ball_en});
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (serve !== 1'b0 || serves != 1) begin
      errors++;
      $display("FAIL serve_width: got serve=%b count=%0d expected 0 and 1", serve, serves);
    end
  endtask
  task automatic test_point();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    vectors++;
    if ({left_score, right_score, ball_en, paddle_en} !== {4'd1, 4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL point_entry: got L=%0d R=%0d ball=%b pad=%b expected 1 0 0 1", left_score, right_score, ball_en, paddle_en);
    end
    for (int i = 1; i <= PF + SF; i++) begin
      step(1'b0, 1'b1, $urandom_range(0, 1), 1'b0);
      vectors++;
      if (serve !== m_serve || ball_en !== (m_ph == P_PLAY)) begin
        errors++;
        $display("FAIL point_to_serve tick %0d: got serve=%b ball=%b expected %b %b", i, serve, ball_en, m_serve, m_ph == P_PLAY);
      end
    end
    vectors++;
    if ({serve, serve_dir} !== 2'b11) begin
      errors++;
      $display("FAIL point_serve_dir: got %b expected 11", {serve, serve_dir});
    end
  endtask
  task automatic test_double_exit();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (left_score !== 4'd1 || right_score !== 4'd0 || ball_en !== 1'b0 || serve_dir !== 1'b1) begin
      errors++;
      $display("FAIL double_exit: got L=%0d R=%0d ball=%b dir=%b expected 1 0 0 1", left_score, right_score, ball_en, serve_dir);
    end
    repeat (PF + SF) step(1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({serve, serve_dir, ball_en} !== 3'b111) begin
      errors++;
      $display("FAIL double_exit_serve: got %b expected 111", {serve, serve_dir, ball_en});
    end
  endtask
  task automatic test_game_over();
    for (int k = 0; k < 10 && m_right < WS - 1; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (PF + SF) step(1'b0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if ({serve, serve_dir, right_score} !== {1'b1, 1'b0, 4'(m_right)}) begin
        errors++;
        $display("FAIL rally_%0d: got serve=%b dir=%b R=%0d expected 1 0 %0d", k, serve, serve_dir, right_score, m_right);
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if ({right_score, game_over, winner, ball_en, paddle_en} !== {4'd9, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL game_over: got R=%0d over=%b win=%b ball=%b pad=%b expected 9 1 1 0 0", right_score, game_over, winner, ball_en, paddle_en);
    end
    repeat (5) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      vectors++;
      if ({left_score, right_score, game_over, winner, serve} !== {4'd1, 4'd9, 1'b1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL over_hold: got L=%0d R=%0d over=%b win=%b serve=%b expected 1 9 1 1 0", left_score, right_score, game_over, winner, serve);
      end
    end
    press_start();
    vectors++;
    if ({left_score, right_score, game_over, paddle_en, serve_dir} !== {4'd0, 4'd0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL restart: got L=%0d R=%0d over=%b pad=%b dir=%b expected 0 0 0 1 1", left_score, right_score, game_over, paddle_en, serve_dir);
    end
  endtask
  task automatic test_reset_mid_arm();
    repeat (SF - 10) step(1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    model_reset();
    vectors++;
    if ({serve, serve_dir, ball_en, paddle_en, game_over, winner, left_score, right_score} !== 14'b01_0000_0000_0000) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", {serve, serve_dir, ball_en, paddle_en, game_over, winner, left_score, right_score}, 14'b01_0000_0000_0000);
    end
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if ({serve, ball_en, paddle_en} !== 3'b000) begin
        errors++;
        $display("FAIL no_serve_after_reset cycle %0d: got %b expected 000", i, {serve, ball_en, paddle_en});
      end
    end
  endtask
  task automatic test_glitch_start();
    evt_count = 0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0 && $urandom_range(0, 2) == 0) begin
        start_btn = 1'b0; #2; start_btn = 1'b1; #1;
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (evt_count != 1 || paddle_en !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start: got events=%0d pad=%b expected 1 1", evt_count, paddle_en);
    end
  endtask
  task automatic test_random();
    logic [14:0] got, exp;
    bit b = 1'b0;
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) b = ~b;
      step(b, $urandom_range(0, 1) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
      got = {serve, serve_dir, ball_en, paddle_en, game_over, left_score, right_score};
      exp = {m_serve, m_dir, m_ph == P_PLAY, m_ph inside {P_ARM, P_PLAY, P_POINT}, m_ph == P_OVER, 4'(m_left), 4'(m_right)};
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random cycle %0d: got %b expected %b", i, got, exp);
      end
      if (m_ph == P_OVER) begin
        vectors++;
        if (winner !== m_win) begin
          errors++;
          $display("FAIL random_winner cycle %0d: got %b expected %b", i, winner, m_win);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_serve();
    test_point();
    test_double_exit();
    test_game_over();
    test_reset_mid_arm();
    test_glitch_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
